ula_operand_fifo: RTL and testbench

//  Parametrised successor of the combinational operand muxes (4x1/2x1 select, cmp2 OR-mask, incdec force).

---
 rtl/ula_operand_fifo.sv | 96 +++++++++
 tb/tb_ula_operand_fifo.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ula_operand_fifo.sv
// Operand select/modify stage feeding a DEPTH-entry FIFO of (A,B) pairs toward the ULA.
// Valid/ready on both sides; the head pair is gated to zero while the FIFO is empty.
module ula_operand_fifo #(
    parameter int TAM   = 16,
    parameter int NIN   = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 err_clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NIN*TAM-1:0]   MUX_in,
    input  logic [$clog2(NIN)-1:0] SEL_A,
    input  logic [$clog2(NIN)-1:0] SEL_B,
    input  logic                 cmp2,
    input  logic                 incdec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TAM-1:0]       A_ULA,
    output logic [TAM-1:0]       B_ULA,
    output logic [$clog2(DEPTH):0] level,
    output logic                 sel_err
);

    localparam int SELW = $clog2(NIN);
    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int PW   = $clog2(DEPTH);

    logic [TAM-1:0]   sel_a, sel_b, a_mod, b_mod;
    logic             bad_a, bad_b;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [2*TAM-1:0] mem [DEPTH];
    logic [2*TAM-1:0] head;
    logic             full, empty, push, pop;

    // Out-of-range selects read as zero rather than aliasing onto a real channel.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NIN; k++) begin
            if (int'(SEL_A) == k) sel_a = MUX_in[k*TAM +: TAM];
            if (int'(SEL_B) == k) sel_b = MUX_in[k*TAM +: TAM];
        end
    end

    assign bad_a = int'(SEL_A) >= NIN;
    assign bad_b = int'(SEL_B) >= NIN;

    assign a_mod = sel_a | {TAM{cmp2}};
    assign b_mod = {sel_b[TAM-1:1] & ~{(TAM-1){incdec}}, sel_b[0] | incdec};

    assign full      = (level == CW'(DEPTH));
    assign empty     = (level == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + CW'(1);
                2'b01:   level <= level - CW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage is intentionally not reset; level gating hides stale entries.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= {a_mod, b_mod};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       sel_err <= 1'b0;
        else if (push && (bad_a || bad_b)) sel_err <= 1'b1;
        else if (err_clr)                 sel_err <= 1'b0;
    end

    assign head  = mem[rd_ptr];
    assign A_ULA = empty ? '0 : head[2*TAM-1:TAM];
    assign B_ULA = empty ? '0 : head[TAM-1:0];

endmodule

// File: tb/tb_ula_operand_fifo.sv
// Randomised bench for ula_operand_fifo (NIN=3 so out-of-range selects are reachable),
// compared every cycle against a queue-based reference model.
module tb_ula_operand_fifo;

    localparam int TAM   = 16;
    localparam int NIN   = 3;
    localparam int DEPTH = 4;
    localparam int SELW  = $clog2(NIN);
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                flush, err_clr, in_valid, in_ready;
    logic [NIN*TAM-1:0]  mux_in;
    logic [SELW-1:0]     sel_a, sel_b;
    logic                cmp2, incdec, out_valid, out_ready;
    logic [TAM-1:0]      a_ula, b_ula;
    logic [CW-1:0]       level;
    logic                sel_err;

    logic [TAM-1:0]      src [NIN];
    logic [2*TAM-1:0]    q [$];
    bit                  err_m;
    int                  n_vec = 0;
    int                  n_err = 0;

    assign mux_in = {src[2], src[1], src[0]};

    always #5 clk = ~clk;

    ula_operand_fifo #(.TAM(TAM), .NIN(NIN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .err_clr(err_clr),
        .in_valid(in_valid), .in_ready(in_ready), .MUX_in(mux_in),
        .SEL_A(sel_a), .SEL_B(sel_b), .cmp2(cmp2), .incdec(incdec),
        .out_valid(out_valid), .out_ready(out_ready),
        .A_ULA(a_ula), .B_ULA(b_ula), .level(level), .sel_err(sel_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [2*TAM-1:0] h;
        h = (q.size() != 0) ? q[0] : '0;
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        chk("in_ready",  {31'd0, in_ready},  {31'd0, q.size() != DEPTH});
        chk("level",     32'(level),         32'(q.size()));
        chk("A_ULA",     32'(a_ula),         32'(h[2*TAM-1:TAM]));
        chk("B_ULA",     32'(b_ula),         32'(h[TAM-1:0]));
        chk("sel_err",   {31'd0, sel_err},   {31'd0, err_m});
    endtask

    // One clock: drive while clk is low, update model on the edge, check on the falling edge.
    task automatic step(input bit v, input bit r, input bit fl, input bit ec,
                        input bit c2, input bit id, input int sa, input int sb);
        logic [TAM-1:0] ea, eb;
        bit p_push, p_pop;
        in_valid = v; out_ready = r; flush = fl; err_clr = ec;
        cmp2 = c2; incdec = id;
        sel_a = SELW'(sa); sel_b = SELW'(sb);
        @(posedge clk);
        ea = (sa < NIN) ? src[sa] : '0;
        eb = (sb < NIN) ? src[sb] : '0;
        if (c2) ea = '1;
        if (id) eb = TAM'(1);
        p_push = v && (q.size() < DEPTH);
        p_pop  = r && (q.size() > 0);
        if (p_push && (sa >= NIN || sb >= NIN)) err_m = 1'b1;
        else if (ec) err_m = 1'b0;
        if (fl) q.delete();
        else begin
            if (p_pop)  void'(q.pop_front());
            if (p_push) q.push_back({ea, eb});
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic rand_src();
        for (int k = 0; k < NIN; k++) src[k] = TAM'($urandom);
    endtask

    initial begin
        rst_n = 1'b0; flush = 0; err_clr = 0; in_valid = 0; out_ready = 0;
        cmp2 = 0; incdec = 0; sel_a = '0; sel_b = '0;
        for (int k = 0; k < NIN; k++) src[k] = '0;
        err_m = 0;
        #7;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // basic select
        src[0] = 16'hAAAA; src[1] = 16'h00F0; src[2] = 16'h1234;
        step(1, 0, 0, 0, 0, 0, 2, 1);
        chk("t1_A", 32'(a_ula), 32'h1234);
        chk("t1_B", 32'(b_ula), 32'h00F0);
        chk("t1_level", 32'(level), 32'd1);
        step(0, 1, 0, 0, 0, 0, 0, 0);

        // modifiers
        rand_src();
        step(1, 0, 0, 0, 1, 1, 0, 2);
        chk("mod_A", 32'(a_ula), 32'hFFFF);
        chk("mod_B", 32'(b_ula), 32'h0001);
        step(0, 1, 0, 0, 0, 0, 0, 0);

        // fill, overflow attempt, pop-only while full, drain
        for (int i = 0; i < 5; i++) begin
            rand_src();
            step(1, 0, 0, 0, 0, 0, i % 3, (i + 1) % 3);
        end
        chk("full_level", 32'(level), 32'd4);
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        rand_src();
        step(1, 1, 0, 0, 0, 0, 1, 2);
        chk("fullpop_level", 32'(level), 32'd3);
        chk("fullpop_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0);

        // out-of-range select and sticky error
        rand_src();
        step(1, 0, 0, 0, 0, 0, 3, 0);
        chk("bad_A", 32'(a_ula), 32'd0);
        chk("bad_err", {31'd0, sel_err}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 1, 3);
        chk("err_set_wins", {31'd0, sel_err}, 32'd1);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        chk("err_clr", {31'd0, sel_err}, 32'd0);

        // flush with push and pop
        step(1, 0, 0, 0, 0, 0, 0, 1);
        chk("pre_flush_level", 32'(level), 32'd3);
        step(1, 1, 1, 0, 0, 0, 2, 2);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);

        // random traffic with a mid-stream asynchronous reset
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                rst_n = 1'b0;
                #1;
                q.delete();
                err_m = 0;
                compare_all();
                rst_n = 1'b1;
            end
            rand_src();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
